// File: rtl/mdio_arbiter_pkg.sv
// Shared types for the MDIO arbiter slice: frame layout,
// clause-22 field codes and the sequencer state encoding.
package mdio_pkg;

   localparam logic [1:0] ST_SOF = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;

   // Clause-22 frame, MSB first: ST, OP, PHYAD, REGAD, TA, DATA
   typedef struct packed {
      logic [1:0]  st;
      logic [1:0]  op;
      logic [4:0]  phyad;
      logic [4:0]  regad;
      logic [1:0]  ta;
      logic [15:0] data;
   } frame_t;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      START,
      WAIT_OE,
      BUSY,
      DONE
   } state_t;

   function automatic logic frame_ok(input logic [1:0] st,
                                     input logic [1:0] op);
      return (st == ST_SOF) && ((op == OP_WR) || (op == OP_RD));
   endfunction

endpackage

// File: rtl/mdio_arbiter_if.sv
// Requester and controller signals of the MDIO arbiter.
// slave = arbiter side, master = clients/controller side.
interface mdio_arbiter_if;

   logic        req0;
   logic        req1;
   logic [31:0] frame0;
   logic [31:0] frame1;
   logic        done0;
   logic        done1;
   logic        err0;
   logic        err1;
   logic [15:0] rdata0;
   logic [15:0] rdata1;
   logic        mdio_start;
   logic [31:0] t_data;
   logic        mdio_oe;
   logic        data_rdy;
   logic [15:0] rd_data;
   logic        busy;

   modport slave (
      input  req0, req1, frame0, frame1,
      input  mdio_oe, data_rdy, rd_data,
      output done0, done1, err0, err1,
      output rdata0, rdata1,
      output mdio_start, t_data, busy
   );

   modport master (
      output req0, req1, frame0, frame1,
      output mdio_oe, data_rdy, rd_data,
      input  done0, done1, err0, err1,
      input  rdata0, rdata1,
      input  mdio_start, t_data, busy
   );

endinterface

// File: rtl/mdio_arbiter_rr_arb.sv
// Two-way round-robin arbiter; last_grant resets to port 1
// so that port 0 wins the first tie after reset.
module mdio_rr_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_grant
);

   logic r_last_grant;

   // Lone requester wins; on a tie, the port that did not win last
   always_comb begin
      o_grant = 2'b00;
      unique case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

   // Remember the winner whenever a grant is actually taken
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_last_grant <= 1'b1;
      else if (i_advance && (|o_grant))
         r_last_grant <= o_grant[1];
   end

endmodule

// File: rtl/mdio_arbiter.sv
// Arbitrates two MDIO requesters onto one controller and
// sequences each frame through validation, start and completion.
module mdio_arbiter
   import mdio_pkg::*;
#(
   parameter int TIMEOUT_CYC = 4096
) (
   input logic           clk,
   input logic           reset,
   mdio_arbiter_if.slave bus
);

   localparam int          CW       = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 2);

   state_t        r_state;
   state_t        w_next;
   frame_t        r_tdata;
   logic          r_owner;
   logic          r_err;
   logic          r_oe_q;
   logic [CW-1:0] r_cnt;
   logic [15:0]   r_rdata0;
   logic [15:0]   r_rdata1;

   logic [1:0]    w_grant;
   logic          w_adv;
   logic          w_err_nx;
   logic          w_cap;
   logic          w_tmo;
   logic          w_is_rd;
   logic          w_oe_fall;

   mdio_rr_arb u_arb (
      .clk       (clk),
      .reset     (reset),
      .i_req     ({bus.req1, bus.req0}),
      .i_advance (w_adv),
      .o_grant   (w_grant)
   );

   // The counter value that becomes CNT_MAX on this edge ends the wait
   assign w_tmo     = (r_cnt == CNT_LAST);
   assign w_is_rd   = (r_tdata.op == OP_RD);
   assign w_oe_fall = r_oe_q && !bus.mdio_oe;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Next state, error flag and read-capture decisions
   always_comb begin
      w_next   = r_state;
      w_err_nx = r_err;
      w_cap    = 1'b0;
      w_adv    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (|w_grant) begin
               w_adv    = 1'b1;
               w_next   = CHECK;
               w_err_nx = 1'b0;
            end
         end
         CHECK: begin
            if (frame_ok(r_tdata.st, r_tdata.op)) begin
               w_next = START;
            end else begin
               w_next   = DONE;
               w_err_nx = 1'b1;
            end
         end
         START: w_next = WAIT_OE;
         WAIT_OE: begin
            if (w_tmo) begin
               w_next   = DONE;
               w_err_nx = 1'b1;
            end else if (bus.mdio_oe) begin
               w_next = BUSY;
            end
         end
         BUSY: begin
            // reads ignore the turnaround release of mdio_oe
            if (w_is_rd && bus.data_rdy) begin
               w_cap  = 1'b1;
               w_next = DONE;
            end else if (!w_is_rd && w_oe_fall) begin
               w_next = DONE;
            end else if (w_tmo) begin
               w_next   = DONE;
               w_err_nx = 1'b1;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Frame latch, owner and error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tdata <= '0;
         r_owner <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_err_nx;
         if (w_adv) begin
            r_owner <= w_grant[1];
            r_tdata <= w_grant[1] ? frame_t'(bus.frame1)
                                  : frame_t'(bus.frame0);
         end
      end
   end

   // Saturating timeout counter, cleared on start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (r_state == START)
         r_cnt <= '0;
      else if ((r_state == WAIT_OE || r_state == BUSY) &&
               (r_cnt != CNT_MAX))
         r_cnt <= r_cnt + 1'b1;
   end

   // Previous mdio_oe for falling-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_oe_q <= 1'b0;
      else
         r_oe_q <= bus.mdio_oe;
   end

   // Per-port read data, updated only by a completing read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else if (w_cap) begin
         if (r_owner)
            r_rdata1 <= bus.rd_data;
         else
            r_rdata0 <= bus.rd_data;
      end
   end

   assign bus.mdio_start = (r_state == START);
   assign bus.busy       = (r_state != IDLE);
   assign bus.t_data     = r_tdata;
   assign bus.done0      = (r_state == DONE) && !r_owner;
   assign bus.done1      = (r_state == DONE) &&  r_owner;
   assign bus.err0       = bus.done0 && r_err;
   assign bus.err1       = bus.done1 && r_err;
   assign bus.rdata0     = r_rdata0;
   assign bus.rdata1     = r_rdata1;

endmodule
